// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Valid/ready ALU (ADD/SUB/AND/OR/SLL/SRA) with compare flags and
//            illegal-op detection. Optional macro ALU_SERIAL_SHIFT_EN selects a
//            one-bit-per-cycle shifter instead of the single-cycle barrel shifter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  modEnable,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_shiftamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow,
    output logic        err_illegal
);

    localparam logic [5:0] c_OP_ADD = 6'b000001;
    localparam logic [5:0] c_OP_SUB = 6'b000010;
    localparam logic [5:0] c_OP_AND = 6'b000100;
    localparam logic [5:0] c_OP_OR  = 6'b001000;
    localparam logic [5:0] c_OP_SLL = 6'b010000;
    localparam logic [5:0] c_OP_SRA = 6'b100000;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
`ifdef ALU_SERIAL_SHIFT_EN
    localparam logic [1:0] c_S_SHIFT = 2'd1;
`endif
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic        w_accept;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_ne;
    logic        w_lt;
    logic        w_ov;
    logic        w_err;

    assign in_ready  = (r_state == c_S_IDLE) || ((r_state == c_S_DONE) && out_ready);
    assign out_valid = (r_state == c_S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_sum     = data_operandA + data_operandB;
    assign w_diff    = data_operandA - data_operandB;

    // Anything other than exactly one of the six legal one-hot codes is illegal.
    always_comb begin
        w_result = 32'd0;
        w_ne     = 1'b0;
        w_lt     = 1'b0;
        w_ov     = 1'b0;
        w_err    = 1'b0;
        case (modEnable)
            c_OP_ADD: begin
                w_result = w_sum;
                w_ov     = (data_operandA[31] == data_operandB[31]) && (w_sum[31] != data_operandA[31]);
            end
            c_OP_SUB: begin
                w_result = w_diff;
                w_ov     = (data_operandA[31] != data_operandB[31]) && (w_diff[31] != data_operandA[31]);
                w_lt     = w_diff[31] ^ w_ov;
                w_ne     = |w_diff;
            end
            c_OP_AND: w_result = data_operandA & data_operandB;
            c_OP_OR:  w_result = data_operandA | data_operandB;
`ifdef ALU_SERIAL_SHIFT_EN
            // Only reached here with a zero shift distance; nonzero shifts go serial.
            c_OP_SLL: w_result = data_operandA;
            c_OP_SRA: w_result = data_operandA;
`else
            c_OP_SLL: w_result = data_operandA << ctrl_shiftamt;
            c_OP_SRA: w_result = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
`endif
            default:  w_err = 1'b1;
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    logic [31:0] r_shreg;
    logic [4:0]  r_count;
    logic        r_sra;
    logic [31:0] w_shstep;
    logic        w_start_shift;

    assign w_start_shift = w_accept && ((modEnable == c_OP_SLL) || (modEnable == c_OP_SRA))
                           && (ctrl_shiftamt != 5'd0);
    assign w_shstep      = r_sra ? {r_shreg[31], r_shreg[31:1]} : {r_shreg[30:0], 1'b0};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg <= 32'd0;
            r_count <= 5'd0;
            r_sra   <= 1'b0;
        end else if (w_start_shift) begin
            r_shreg <= data_operandA;
            r_count <= ctrl_shiftamt;
            r_sra   <= (modEnable == c_OP_SRA);
        end else if (r_state == c_S_SHIFT) begin
            r_shreg <= w_shstep;
            r_count <= r_count - 5'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            data_result <= 32'd0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
`ifdef ALU_SERIAL_SHIFT_EN
            if (r_state == c_S_SHIFT) begin
                if (r_count == 5'd1) begin
                    r_state     <= c_S_DONE;
                    data_result <= w_shstep;
                    isNotEqual  <= 1'b0;
                    isLessThan  <= 1'b0;
                    overflow    <= 1'b0;
                    err_illegal <= 1'b0;
                end
            end else if (w_start_shift) begin
                r_state <= c_S_SHIFT;
            end else
`endif
            if (w_accept) begin
                r_state     <= c_S_DONE;
                data_result <= w_result;
                isNotEqual  <= w_ne;
                isLessThan  <= w_lt;
                overflow    <= w_ov;
                err_illegal <= w_err;
            end else if (out_valid && out_ready) begin
                r_state <= c_S_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed scoreboard bench for alu_exec_unit (either build of
//            ALU_SERIAL_SHIFT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  modEnable;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_shiftamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        err_illegal;

    alu_exec_unit dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .modEnable     (modEnable),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_shiftamt (ctrl_shiftamt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .isNotEqual    (isNotEqual),
        .isLessThan    (isLessThan),
        .overflow      (overflow),
        .err_illegal   (err_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef ALU_SERIAL_SHIFT_EN
    localparam int c_SRA4_LAT = 5;
`else
    localparam int c_SRA4_LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic        ne;
        logic        lt;
        logic        ov;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed  = 0;
    int   total   = 0;
    int   n_pop   = 0;
    logic last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Reference model built from signed arithmetic rather than sign-bit rules.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t   e;
        longint s;
        e = '0;
        case (op)
            6'b000001: begin
                e.r  = a + b;
                s    = longint'($signed(a)) + longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'b000010: begin
                e.r  = a - b;
                s    = longint'($signed(a)) - longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.lt = $signed(a) < $signed(b);
                e.ne = (a != b);
            end
            6'b000100: e.r = a & b;
            6'b001000: e.r = a | b;
            6'b010000: e.r = a << sh;
            6'b100000: e.r = $unsigned($signed(a) >>> sh);
            default:   e.err = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: observe handshakes with current inputs, then advance to the next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        last_acc = 1'b0;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    check("result",      data_result, e.r);
                    check("isNotEqual",  {31'd0, isNotEqual},  {31'd0, e.ne});
                    check("isLessThan",  {31'd0, isLessThan},  {31'd0, e.lt});
                    check("overflow",    {31'd0, overflow},    {31'd0, e.ov});
                    check("err_illegal", {31'd0, err_illegal}, {31'd0, e.err});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(modEnable, data_operandA, data_operandB, ctrl_shiftamt));
                last_acc = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        int n;
        in_valid      = 1'b1;
        modEnable     = op;
        data_operandA = a;
        data_operandB = b;
        ctrl_shiftamt = sh;
        n = 0;
        cycle();
        while (!last_acc && n < 50) begin
            cycle();
            n++;
        end
        if (!last_acc) check("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        int lat;
        int p0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        modEnable = 6'd0; data_operandA = 32'd0; data_operandB = 32'd0; ctrl_shiftamt = 5'd0;
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_result",    data_result, 32'd0);
        check("rst_flags",     {28'd0, isNotEqual, isLessThan, overflow, err_illegal}, 32'd0);

        // ADD overflow, visible one cycle after accept
        issue(6'b000001, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", data_result, 32'h80000000);
        check("add_ovf", {31'd0, overflow}, 32'd1);
        drain();

        // SUB -2 - 3
        issue(6'b000010, 32'hFFFFFFFE, 32'h00000003, 5'd0);
        check("sub_result", data_result, 32'hFFFFFFFB);
        check("sub_lt", {31'd0, isLessThan}, 32'd1);
        check("sub_ne", {31'd0, isNotEqual}, 32'd1);
        drain();
        issue(6'b000010, 32'h80000000, 32'h00000001, 5'd0);
        drain();
        issue(6'b000010, 32'h12345678, 32'h12345678, 5'd0);
        drain();

        // SRA latency and in_ready low while shifting
        issue(6'b100000, 32'h80000000, 32'h0, 5'd4);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("shift_in_ready", {31'd0, in_ready}, 32'd0);
            cycle();
            lat++;
        end
        check("sra_latency", lat, c_SRA4_LAT);
        check("sra_result", data_result, 32'hF8000000);
        drain();
        issue(6'b010000, 32'h0000F00D, 32'h0, 5'd0);
        drain();
        issue(6'b010000, 32'h8000F00D, 32'h0, 5'd5);
        drain();
        issue(6'b100000, 32'h7FFFFFFF, 32'h0, 5'd31);
        drain();

        // AND held under backpressure; offered op must be ignored meanwhile
        out_ready = 1'b0;
        issue(6'b000100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        in_valid = 1'b1; modEnable = 6'b001000; data_operandA = 32'h1; data_operandB = 32'h2;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid",    {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready},  32'd0);
            check("hold_result",   data_result, 32'hF000F000);
            if (i < 2) cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("hold_released", {31'd0, out_valid}, 32'd0);
        check("hold_sb_empty", sb.size(), 32'd0);

        // Illegal op code
        issue(6'b000011, 32'h5, 32'h6, 5'd0);
        check("illegal_result", data_result, 32'd0);
        check("illegal_err", {31'd0, err_illegal}, 32'd1);
        drain();
        issue(6'b000000, 32'h5, 32'h6, 5'd0);
        drain();

        // Back-to-back OR at full throughput
        p0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; modEnable = 6'b001000;
            data_operandA = 32'h1 << i; data_operandB = 32'h100 << (i * 4); ctrl_shiftamt = 5'd0;
            cycle();
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        drain();
        check("b2b_count", n_pop - p0, 32'd4);

        // Reset in the middle of a long SLL (or while its result is held)
        out_ready = 1'b0;
        issue(6'b010000, 32'hFFFFFFFF, 32'h0, 5'd31);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
        check("mid_rst_result",   data_result, 32'd0);
        check("mid_rst_flags",    {28'd0, isNotEqual, isLessThan, overflow, err_illegal}, 32'd0);
        cycle();
        check("mid_rst_stays_idle", {31'd0, out_valid}, 32'd0);

        issue(6'b000001, 32'hFFFFFFFF, 32'h00000001, 5'd0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
